// File: rtl/arc4_decrypt_if.sv
// Start handshake plus ciphertext/plaintext memory buses of the ARC4 decryption engine.
// The engine connects through the slave modport; the controller and memories use master.
interface arc4_decrypt_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_rddata;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;

  modport slave (
    input  en, key, ct_rddata, pt_rddata,
    output rdy, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport master (
    output en, key, ct_rddata, pt_rddata,
    input  rdy, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/arc4_decrypt.sv
// ARC4 decryption with a 24-bit key: S init, key scheduling, then keystream XOR of a
// length-prefixed ciphertext into a length-prefixed plaintext memory.
module arc4_decrypt (
  input  logic          clk,
  input  logic          rst_n,
  arc4_decrypt_if.slave bus
);

  typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} state_t;
  typedef enum logic [2:0] {P_HWAIT, P_HLEN, P_STEP, P_CTWAIT, P_WRITE} pstep_t;

  state_t      state_q;
  pstep_t      pstep_q;
  logic [7:0]  s_mem [0:255];
  logic [7:0]  i_q, j_q, len_q;
  logic [8:0]  k_q;
  logic [1:0]  kidx_q;
  logic [23:0] key_q;
  logic        rdy_q, pt_wren_q;
  logic [7:0]  ct_addr_q, pt_addr_q, pt_wrdata_q;

  logic [7:0]  key_byte, swap_i, swap_j, s_i, s_j, pad_idx, pad;
  logic        swap_en;
  logic        unused_pt_rddata;

  always_comb begin
    case (kidx_q)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  // KSA swaps S[i]; PRGA swaps S[i+1]. Both share one combinational swap datapath.
  assign swap_i  = (state_q == KSA) ? i_q : i_q + 8'd1;
  assign s_i     = s_mem[swap_i];
  assign swap_j  = j_q + s_i + ((state_q == KSA) ? key_byte : 8'd0);
  assign s_j     = s_mem[swap_j];
  assign swap_en = (state_q == KSA) ||
                   ((state_q == PRGA) && (pstep_q == P_STEP) && (k_q <= {1'b0, len_q}));
  assign pad_idx = s_mem[i_q] + s_mem[j_q];
  assign pad     = s_mem[pad_idx];

  // Both swap writes read the old contents, so i == j naturally leaves S unchanged.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      s_mem[i_q] <= i_q;
    end else if (swap_en) begin
      s_mem[swap_i] <= s_j;
      s_mem[swap_j] <= s_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pstep_q     <= P_HWAIT;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      len_q       <= 8'd0;
      k_q         <= 9'd0;
      kidx_q      <= 2'd0;
      key_q       <= 24'd0;
      rdy_q       <= 1'b1;
      pt_wren_q   <= 1'b0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en) begin
            key_q   <= bus.key;
            rdy_q   <= 1'b0;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            state_q <= INIT;
          end
        end
        INIT: begin
          i_q <= i_q + 8'd1;
          if (i_q == 8'hff) begin
            kidx_q  <= 2'd0;
            j_q     <= 8'd0;
            state_q <= KSA;
          end
        end
        KSA: begin
          i_q    <= i_q + 8'd1;
          j_q    <= swap_j;
          kidx_q <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          if (i_q == 8'hff) begin
            j_q       <= 8'd0;
            ct_addr_q <= 8'd0;
            pstep_q   <= P_HWAIT;
            state_q   <= PRGA;
          end
        end
        PRGA: begin
          case (pstep_q)
            P_HWAIT: pstep_q <= P_HLEN;
            P_HLEN: begin
              len_q       <= bus.ct_rddata;
              pt_addr_q   <= 8'd0;
              pt_wrdata_q <= bus.ct_rddata;
              pt_wren_q   <= 1'b1;
              k_q         <= 9'd1;
              pstep_q     <= P_STEP;
            end
            P_STEP: begin
              pt_wren_q <= 1'b0;
              if (k_q > {1'b0, len_q}) begin
                state_q <= DONE;
              end else begin
                i_q       <= swap_i;
                j_q       <= swap_j;
                ct_addr_q <= k_q[7:0];
                pstep_q   <= P_CTWAIT;
              end
            end
            P_CTWAIT: pstep_q <= P_WRITE;
            P_WRITE: begin
              pt_addr_q   <= k_q[7:0];
              pt_wrdata_q <= pad ^ bus.ct_rddata;
              pt_wren_q   <= 1'b1;
              k_q         <= k_q + 9'd1;
              pstep_q     <= P_STEP;
            end
            default: pstep_q <= P_HWAIT;
          endcase
        end
        DONE: begin
          rdy_q   <= 1'b1;
          i_q     <= 8'd0;
          j_q     <= 8'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = pt_wren_q;

  assign unused_pt_rddata = ^bus.pt_rddata;

endmodule

// File: tb/tb_arc4_decrypt.sv
// Randomised bench for arc4_decrypt: a plain-array RC4 model predicts every pt write,
// and a published RC4 vector (key "Key") pins both the model and the engine.
module tb_arc4_decrypt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arc4_decrypt_if bus_if ();

  arc4_decrypt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ks     [256];
  logic [7:0] ptxt   [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ctxt   [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int exp_addr_q[$];
  int exp_data_q[$];

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endfunction

  // External synchronous memories.
  always @(posedge clk) begin
    bus_if.ct_rddata <= ct_mem[bus_if.ct_addr];
    bus_if.pt_rddata <= pt_mem[bus_if.pt_addr];
    if (bus_if.pt_wren) pt_mem[bus_if.pt_addr] <= bus_if.pt_wrdata;
  end

  // Every write must be the next one the model predicts.
  always @(negedge clk) begin
    int ea, ed;
    if (rst_n && bus_if.pt_wren) begin
      wr_count++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        chk("pt_addr", bus_if.pt_addr, ea);
        chk("pt_wrdata", bus_if.pt_wrdata, ed);
      end
      $display("pt write addr=%0d data=%02h", bus_if.pt_addr, bus_if.pt_wrdata);
    end
  end

  // Textbook RC4 on integer arrays: fills ks[0..n-1].
  task automatic gen_ks(input logic [23:0] k, input int n);
    int s[256];
    int i, j, t, kb, kk;
    kk = int'(k);
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kb = (kk >> (8 * (2 - (x % 3)))) & 255;
      j = (j + s[x] + kb) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int m = 0; m < n; m++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[m] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic predict(input logic [23:0] k);
    int len;
    len = int'(ct_mem[0]);
    gen_ks(k, len);
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_addr_q.push_back(0);
    exp_data_q.push_back(len);
    for (int m = 1; m <= len; m++) begin
      exp_addr_q.push_back(m);
      exp_data_q.push_back(int'(ct_mem[m] ^ ks[m - 1]));
    end
    wr_count = 0;
  endtask

  task automatic start(input logic [23:0] k);
    @(negedge clk);
    bus_if.key = k;
    bus_if.en  = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_falls", bus_if.rdy, 0);
    @(negedge clk);
    bus_if.en  = 1'b0;
    bus_if.key = 24'($urandom);
  endtask

  task automatic run(input logic [23:0] k, input bit mid_en);
    int len;
    bit done;
    len = int'(ct_mem[0]);
    predict(k);
    start(k);
    done = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      @(negedge clk);
      if (bus_if.rdy) done = 1'b1;
      else bus_if.en = (mid_en && c == 100);
    end
    bus_if.en = 1'b0;
    chk("run_finished", int'(done), 1);
    chk("write_count", wr_count, len + 1);
    chk("pending_writes", exp_addr_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("stays_idle", bus_if.rdy, 1);
    $display("run key=%06h L=%0d writes=%0d", k, len, wr_count);
  endtask

  task automatic fill_ct(input int len);
    ct_mem[0] = 8'(len);
    for (int m = 1; m < 256; m++) ct_mem[m] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    bus_if.en  = 1'b0;
    bus_if.key = 24'd0;
    for (int m = 0; m < 256; m++) begin
      ct_mem[m] = 8'd0;
      pt_mem[m] = 8'd0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy", bus_if.rdy, 1);
    chk("reset_pt_wren", bus_if.pt_wren, 0);
    chk("reset_ct_addr", bus_if.ct_addr, 0);
    chk("reset_pt_addr", bus_if.pt_addr, 0);
    chk("reset_pt_wrdata", bus_if.pt_wrdata, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_rdy", bus_if.rdy, 1);
      chk("idle_pt_wren", bus_if.pt_wren, 0);
      chk("idle_ct_addr", bus_if.ct_addr, 0);
    end
    $display("reset/idle window checked");

    // Published RC4 keystream for key "Key": EB 9F 77 81 ... 19.
    gen_ks(24'h4B6579, 10);
    chk("model_ks0", ks[0], 8'hEB);
    chk("model_ks1", ks[1], 8'h9F);
    chk("model_ks2", ks[2], 8'h77);
    chk("model_ks3", ks[3], 8'h81);
    chk("model_ks9", ks[9], 8'h19);

    ct_mem[0] = 8'd1;
    ct_mem[1] = 8'h00;
    run(24'h000000, 1'b0);

    ct_mem[0] = 8'd9;
    for (int m = 0; m < 9; m++) ct_mem[m + 1] = ctxt[m];
    run(24'h4B6579, 1'b0);
    chk("vector_len", pt_mem[0], 9);
    for (int m = 0; m < 9; m++) chk("vector_plaintext", pt_mem[m + 1], ptxt[m]);

    fill_ct(50);
    run(24'h1E4600, 1'b1);

    fill_ct(0);
    run(24'($urandom), 1'b0);

    fill_ct(255);
    run(24'($urandom), 1'b0);

    // Abort during key scheduling, then a fresh run with another key.
    fill_ct(20);
    predict(24'hA5C3E1);
    start(24'hA5C3E1);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", bus_if.rdy, 1);
    chk("abort_pt_wren", bus_if.pt_wren, 0);
    chk("abort_ct_addr", bus_if.ct_addr, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset asserted mid-KSA");
    fill_ct(20);
    run(24'h3C7E19, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
